// File: rtl/bank_pkg.sv
// Shared constants and types for the bank crossbar reorder buffer.
package bank_pkg;

   localparam int unsigned CH_NUM    = 3;
   localparam int unsigned ROB_DEPTH = 8;
   localparam int unsigned ROB_IDX_W = 3;
   localparam int unsigned DATA_W    = 128;
   localparam int unsigned CH_ID_W   = 2;

   typedef logic [CH_ID_W-1:0]   ch_id_t;
   typedef logic [ROB_IDX_W-1:0] rob_idx_t;

   // Advance a ROB index, wrapping at the configured depth.
   function automatic rob_idx_t rob_next(input rob_idx_t idx, input int unsigned depth);
      if (32'(idx) == depth - 32'd1) begin
         return '0;
      end
      return idx + ROB_IDX_W'(1);
   endfunction

endpackage

// File: rtl/bank_xbar_rob_ch.sv
// Single-channel reorder buffer: slot write port, in-order head drain, credit pulse.
module bank_xbar_rob_ch #(
   parameter int unsigned DATA_W    = bank_pkg::DATA_W,
   parameter int unsigned ROB_DEPTH = bank_pkg::ROB_DEPTH
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    wr_en_i,
   input  bank_pkg::rob_idx_t      wr_idx_i,
   input  logic [DATA_W-1:0]       wr_data_i,
   output logic [ROB_DEPTH-1:0]    slot_valid_o,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_W-1:0]       rsp_data_o,
   output logic                    credit_o
);
   import bank_pkg::*;

   logic [ROB_DEPTH-1:0] valid_q, valid_d;
   logic [DATA_W-1:0]    data_q [ROB_DEPTH];
   rob_idx_t             head_q, head_d;
   logic                 credit_q;
   logic                 drain_c;

   // Head entry is presented directly from state, so valid never depends on ready.
   assign rsp_valid_o  = valid_q[head_q];
   assign rsp_data_o   = data_q[head_q];
   assign drain_c      = rsp_valid_o & rsp_ready_i;
   assign slot_valid_o = valid_q;
   assign credit_o     = credit_q;

   // Next-state valid bits and head: drain clears head, write sets its slot.
   always_comb begin
      valid_d = valid_q;
      head_d  = head_q;
      if (drain_c) begin
         valid_d[head_q] = 1'b0;
         head_d          = rob_next(head_q, ROB_DEPTH);
      end
      if (wr_en_i) begin
         valid_d[wr_idx_i] = 1'b1;
      end
   end

   // Control state; reset discards buffered entries and any pending credit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q  <= '0;
         head_q   <= '0;
         credit_q <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         head_q   <= head_d;
         credit_q <= drain_c;
      end
   end

   // Data storage is not reset; the valid bits qualify it.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

endmodule

// File: rtl/bank_xbar_rob.sv
// Crossbar from the SRAM controller into per-channel reorder buffers.
module bank_xbar_rob #(
   parameter int unsigned DATA_W    = 128,
   parameter int unsigned ROB_DEPTH = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              sc_xbar_valid_i,
   output logic              sc_xbar_ready_o,
   input  logic [1:0]        sc_xbar_channel_id_i,
   input  logic [2:0]        sc_xbar_rob_num_i,
   input  logic [DATA_W-1:0] sc_xbar_data_i,
   output logic              ch0_rsp_valid_o,
   input  logic              ch0_rsp_ready_i,
   output logic [DATA_W-1:0] ch0_rsp_data_o,
   output logic              ch1_rsp_valid_o,
   input  logic              ch1_rsp_ready_i,
   output logic [DATA_W-1:0] ch1_rsp_data_o,
   output logic              ch2_rsp_valid_o,
   input  logic              ch2_rsp_ready_i,
   output logic [DATA_W-1:0] ch2_rsp_data_o,
   output logic              xbar_isu_ch0_credit_o,
   output logic              xbar_isu_ch1_credit_o,
   output logic              xbar_isu_ch2_credit_o,
   output logic              err_illegal_ch_o
);
   import bank_pkg::*;

   logic [CH_NUM-1:0]                 wr_en_c;
   logic [CH_NUM-1:0]                 rsp_valid;
   logic [CH_NUM-1:0]                 rsp_ready;
   logic [CH_NUM-1:0]                 credit;
   logic [CH_NUM-1:0][DATA_W-1:0]     rsp_data;
   logic [CH_NUM-1:0][ROB_DEPTH-1:0]  slot_valid;
   logic                              legal_ch_c;
   logic                              slot_busy_c;
   logic                              err_q;

   assign legal_ch_c = (32'(sc_xbar_channel_id_i) < CH_NUM);

   // Occupancy of the addressed slot on the addressed channel.
   always_comb begin
      slot_busy_c = 1'b0;
      for (int unsigned n = 0; n < CH_NUM; n++) begin
         if (sc_xbar_channel_id_i == CH_ID_W'(n)) begin
            slot_busy_c = slot_valid[n][sc_xbar_rob_num_i];
         end
      end
   end

   // Illegal channels are always sunk; legal ones stall on an occupied slot.
   assign sc_xbar_ready_o = ~legal_ch_c | ~slot_busy_c;

   // Channel decode of an accepted response into a single write enable.
   always_comb begin
      wr_en_c = '0;
      for (int unsigned n = 0; n < CH_NUM; n++) begin
         wr_en_c[n] = sc_xbar_valid_i & sc_xbar_ready_o & legal_ch_c &
                      (sc_xbar_channel_id_i == CH_ID_W'(n));
      end
   end

   assign rsp_ready = {ch2_rsp_ready_i, ch1_rsp_ready_i, ch0_rsp_ready_i};

   for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
      bank_xbar_rob_ch #(
         .DATA_W    (DATA_W),
         .ROB_DEPTH (ROB_DEPTH)
      ) u_ch (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .wr_en_i      (wr_en_c[n]),
         .wr_idx_i     (sc_xbar_rob_num_i),
         .wr_data_i    (sc_xbar_data_i),
         .slot_valid_o (slot_valid[n]),
         .rsp_valid_o  (rsp_valid[n]),
         .rsp_ready_i  (rsp_ready[n]),
         .rsp_data_o   (rsp_data[n]),
         .credit_o     (credit[n])
      );
   end

   // Sticky flag for a response addressed to a nonexistent channel.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if (sc_xbar_valid_i && !legal_ch_c) begin
         err_q <= 1'b1;
      end
   end

   assign err_illegal_ch_o      = err_q;
   assign ch0_rsp_valid_o       = rsp_valid[0];
   assign ch1_rsp_valid_o       = rsp_valid[1];
   assign ch2_rsp_valid_o       = rsp_valid[2];
   assign ch0_rsp_data_o        = rsp_data[0];
   assign ch1_rsp_data_o        = rsp_data[1];
   assign ch2_rsp_data_o        = rsp_data[2];
   assign xbar_isu_ch0_credit_o = credit[0];
   assign xbar_isu_ch1_credit_o = credit[1];
   assign xbar_isu_ch2_credit_o = credit[2];

endmodule

// File: doc/bank_xbar_rob.md
BANK_XBAR_ROB -- requirements
Module: bank_xbar_rob

Interface
REQ-001 The block SHALL have parameter DATA_W, default 128, response data width.
REQ-002 The block SHALL have parameter ROB_DEPTH, default 8, entries per channel, indexed by 3-bit rob_num.
REQ-003 The block SHALL have input clk_i, 1 bit, clock; all state updates on its rising edge.
REQ-004 The block SHALL have input rst_i, 1 bit, reset: asynchronous, active-high.
REQ-005 The block SHALL have input sc_xbar_valid_i, 1 bit: SRAM-controller response valid.
REQ-006 The block SHALL have output sc_xbar_ready_o, 1 bit: response accepted.
REQ-007 The block SHALL have input sc_xbar_channel_id_i, 2 bits: target channel, 0..2 legal.
REQ-008 The block SHALL have input sc_xbar_rob_num_i, 3 bits: ROB slot allocated by ISU.
REQ-009 The block SHALL have input sc_xbar_data_i, DATA_W bits: read data.
REQ-010 The block SHALL have, for N=0..2, output chN_rsp_valid_o, 1 bit: in-order response valid.
REQ-011 The block SHALL have, for N=0..2, input chN_rsp_ready_i, 1 bit: channel consumer ready.
REQ-012 The block SHALL have, for N=0..2, output chN_rsp_data_o, DATA_W bits: response data.
REQ-013 The block SHALL have, for N=0..2, output xbar_isu_chN_credit_o, 1 bit: one-cycle pulse, one ROB slot freed.
REQ-014 The block SHALL have output err_illegal_ch_o, 1 bit: sticky, a response arrived with channel_id 3.

Function
REQ-015 Each channel SHALL hold ROB_DEPTH entries, each with a valid bit and DATA_W data, plus a 3-bit head pointer.
REQ-016 sc_xbar_ready_o SHALL be combinational: 1 when channel_id==3, or when entry[channel_id][rob_num] is invalid; 0 otherwise.
REQ-017 On sc_xbar_valid_i&&sc_xbar_ready_o with a legal channel, the entry SHALL be written and set valid at the next edge.
REQ-018 A write to an entry already valid SHALL be back-pressured (ready 0) until that entry drains; no overwrite ever occurs.
REQ-019 chN_rsp_valid_o SHALL equal valid[head], and chN_rsp_data_o SHALL equal data[head]; a write at edge T is visible at the output from T+1 (1-cycle minimum latency).
REQ-020 On chN_rsp_valid_o&&chN_rsp_ready_i, entry[head] SHALL be cleared and head SHALL increment modulo ROB_DEPTH (7 wraps to 0).
REQ-021 xbar_isu_chN_credit_o SHALL be registered and pulse high for exactly the one cycle after each drain handshake.
REQ-022 Out-of-order arrivals SHALL be held until all older slots (head onward) have arrived and drained; output order is strictly rob_num order from head.
REQ-023 A write to slot X and a drain of a different slot Y in the same cycle SHALL both take effect; the same slot cannot be written and drained in one cycle (REQ-018).
REQ-024 Channels SHALL be fully independent; a stalled channel SHALL NOT block drains of the others.
REQ-025 A response with channel_id 3 SHALL be accepted and discarded, and SHALL set err_illegal_ch_o (cleared only by reset).
REQ-026 chN_rsp_valid_o SHALL NOT depend combinationally on chN_rsp_ready_i.

Reset
REQ-027 On rst_i, all valid bits, head pointers, credit outputs and err_illegal_ch_o SHALL clear to 0 immediately; data arrays are not reset.
REQ-028 On reset mid-operation, all buffered responses SHALL be discarded and no credit pulse SHALL be emitted for them.
REQ-029 All rsp_valid outputs SHALL be 0 during reset; sc_xbar_ready_o SHALL be 1 (all entries invalid).

Structure
REQ-030 Shared package bank_pkg SHALL hold CH_NUM=3, ROB_DEPTH=8, ROB_IDX_W=3, and DATA_W=128.
REQ-031 One sub-module bank_xbar_rob_ch (single-channel ROB: write port, head drain, credit register) SHALL be instantiated CH_NUM times; the top holds the channel decode, ready mux, and error flag.

Verification
REQ-032 In-order: ch0 writes rob 0,1,2 back-to-back, rsp_ready=1 -> ch0 outputs data in order 0,1,2 starting cycle 1 after the first write; three credit pulses.
REQ-033 Reorder: ch1 writes rob 2, then 1, then 0 -> no rsp_valid until rob 0 arrives, then 0,1,2 on consecutive cycles.
REQ-034 Wrap/collision: ch2 fills all 8 slots with rsp_ready=0, then writes rob 3 again -> ready_o=0; raise ready -> slot 3 accepted after it drains; head wraps 7->0.
REQ-035 Independence: ch0 rsp_ready=0 while ch1 receives rob 0 -> ch1 drains and credits normally; ch0 holds.
REQ-036 Illegal channel: valid with channel_id=3 -> ready_o=1, err_illegal_ch_o=1 next cycle, no rsp_valid, no credit.
REQ-037 Reset mid-flight: 4 entries buffered on ch0, assert rst_i -> all outputs 0 immediately; after release, rob 0 write drains with head 0.
